// File: rtl/vx_socket_mem_arb.sv
// vx_socket_mem_arb: round-robin arbiter sharing one L2 request port among NUM_REQS
// socket requesters, with a one-entry registered request stage and a combinational
// tag-indexed response demux.
// Optional build macro VX_SOCKET_ARB_PERF_EN adds the saturating perf_stalls counter.
module vx_socket_mem_arb #(
    parameter int unsigned NUM_REQS   = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_SIZE  = 64,
    parameter int unsigned TAG_WIDTH  = 8,
`ifdef VX_SOCKET_ARB_PERF_EN
    parameter int unsigned PERF_CTR_BITS = 44,
`endif
    localparam int unsigned SEL_BITS   = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
    localparam int unsigned DATA_WIDTH = DATA_SIZE * 8,
    localparam int unsigned XTAG_WIDTH = TAG_WIDTH + SEL_BITS
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQS-1:0]              req_valid_in,
    input  logic [NUM_REQS-1:0]              req_rw_in,
    input  logic [NUM_REQS*ADDR_WIDTH-1:0]   req_addr_in,
    input  logic [NUM_REQS*DATA_WIDTH-1:0]   req_data_in,
    input  logic [NUM_REQS*DATA_SIZE-1:0]    req_byteen_in,
    input  logic [NUM_REQS*TAG_WIDTH-1:0]    req_tag_in,
    output logic [NUM_REQS-1:0]              req_ready_in,
    output logic [NUM_REQS-1:0]              rsp_valid_out,
    output logic [DATA_WIDTH-1:0]            rsp_data_out,
    output logic [TAG_WIDTH-1:0]             rsp_tag_out,
    input  logic [NUM_REQS-1:0]              rsp_ready_out,
    output logic                             mem_req_valid,
    output logic                             mem_req_rw,
    output logic [ADDR_WIDTH-1:0]            mem_req_addr,
    output logic [DATA_WIDTH-1:0]            mem_req_data,
    output logic [DATA_SIZE-1:0]             mem_req_byteen,
    output logic [XTAG_WIDTH-1:0]            mem_req_tag,
    input  logic                             mem_req_ready,
    input  logic                             mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]            mem_rsp_data,
    input  logic [XTAG_WIDTH-1:0]            mem_rsp_tag,
    output logic                             mem_rsp_ready
`ifdef VX_SOCKET_ARB_PERF_EN
    ,
    output logic [PERF_CTR_BITS-1:0]         perf_stalls
`endif
);

    // Output stage
    logic                  buf_valid;
    logic                  buf_rw;
    logic [ADDR_WIDTH-1:0] buf_addr;
    logic [DATA_WIDTH-1:0] buf_data;
    logic [DATA_SIZE-1:0]  buf_byteen;
    logic [TAG_WIDTH-1:0]  buf_tag;
    logic [SEL_BITS-1:0]   buf_idx;

    // Arbitration
    logic [SEL_BITS-1:0]   rr_ptr;
    logic [NUM_REQS-1:0]   grant;
    logic [SEL_BITS-1:0]   grant_idx;
    logic [SEL_BITS-1:0]   next_ptr;
    logic [SEL_BITS-1:0]   cand;
    logic                  any_valid;
    logic                  enq;

    // Response demux
    logic [SEL_BITS-1:0]   rsp_sel;
    logic                  rsp_in_range;

    assign any_valid = |req_valid_in;
    assign enq       = !buf_valid || mem_req_ready;
    assign next_ptr  = SEL_BITS'((32'(grant_idx) + 32'd1) % NUM_REQS);

    // Round-robin search from rr_ptr; scanning farthest-first lets the nearest valid win.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_REQS; k++) begin
            cand = SEL_BITS'((32'(rr_ptr) + NUM_REQS - 1 - k) % NUM_REQS);
            if (req_valid_in[cand]) begin
                grant       = '0;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Handshake is suppressed during reset so no request is accepted and then lost.
    assign req_ready_in = (enq && !reset) ? grant : '0;

    // Buffer valid flag and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid <= 1'b0;
            rr_ptr    <= '0;
        end else if (enq) begin
            buf_valid <= any_valid;
            if (any_valid) begin
                rr_ptr <= next_ptr;
            end
        end
    end

    // Capture the granted request payload; contents are don't-care while buf_valid is 0.
    always_ff @(posedge clk) begin
        if (enq && any_valid) begin
            buf_rw     <= req_rw_in[grant_idx];
            buf_addr   <= req_addr_in[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
            buf_data   <= req_data_in[grant_idx*DATA_WIDTH +: DATA_WIDTH];
            buf_byteen <= req_byteen_in[grant_idx*DATA_SIZE +: DATA_SIZE];
            buf_tag    <= req_tag_in[grant_idx*TAG_WIDTH +: TAG_WIDTH];
            buf_idx    <= grant_idx;
        end
    end

    assign mem_req_valid  = buf_valid;
    assign mem_req_rw     = buf_rw;
    assign mem_req_addr   = buf_addr;
    assign mem_req_data   = buf_data;
    assign mem_req_byteen = buf_byteen;
    assign mem_req_tag    = {buf_tag, buf_idx};

    assign rsp_sel      = mem_rsp_tag[SEL_BITS-1:0];
    assign rsp_in_range = (32'(rsp_sel) < NUM_REQS);
    assign rsp_tag_out  = mem_rsp_tag[SEL_BITS +: TAG_WIDTH];
    assign rsp_data_out = mem_rsp_data;

    // Route the response by index bits; unknown indices are accepted and dropped.
    always_comb begin
        rsp_valid_out = '0;
        mem_rsp_ready = 1'b1;
        if (rsp_in_range) begin
            rsp_valid_out[rsp_sel] = mem_rsp_valid;
            mem_rsp_ready          = rsp_ready_out[rsp_sel];
        end
    end

`ifdef VX_SOCKET_ARB_PERF_EN
    logic [PERF_CTR_BITS-1:0] stall_cnt;

    // Count cycles where someone is requesting but the output stage cannot take it.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (any_valid && !enq && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + PERF_CTR_BITS'(1);
        end
    end

    assign perf_stalls = stall_cnt;
`endif

`ifndef SYNTHESIS
    // A response index with no matching requester indicates a tag corruption upstream.
    rsp_sel_in_range : assert property (@(posedge clk) disable iff (reset)
        mem_rsp_valid |-> rsp_in_range);
`endif

endmodule

// File: tb/tb_vx_socket_mem_arb.sv
// Bench for vx_socket_mem_arb: table-driven request vectors with a scoreboard of
// expected L2-side requests, plus hand sequences for responses, reset and NUM_REQS=1.
module tb_vx_socket_mem_arb;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DS = 64;
    localparam int DW = DS * 8;
    localparam int TW = 8;
    localparam int XT = TW + 2;
    localparam int NV = 18;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic [N-1:0]    req_valid_in, req_rw_in, req_ready_in;
    logic [N*AW-1:0] req_addr_in;
    logic [N*DW-1:0] req_data_in;
    logic [N*DS-1:0] req_byteen_in;
    logic [N*TW-1:0] req_tag_in;
    logic [N-1:0]    rsp_valid_out, rsp_ready_out;
    logic [DW-1:0]   rsp_data_out;
    logic [TW-1:0]   rsp_tag_out;
    logic            mem_req_valid, mem_req_rw, mem_req_ready;
    logic [AW-1:0]   mem_req_addr;
    logic [DW-1:0]   mem_req_data;
    logic [DS-1:0]   mem_req_byteen;
    logic [XT-1:0]   mem_req_tag;
    logic            mem_rsp_valid, mem_rsp_ready;
    logic [DW-1:0]   mem_rsp_data;
    logic [XT-1:0]   mem_rsp_tag;
`ifdef VX_SOCKET_ARB_PERF_EN
    logic [43:0]     perf_stalls, d1_perf;
`endif

    // NUM_REQS=1 instance, 4-byte lines
    logic        d1_valid, d1_rw, d1_ready, d1_rsp_valid, d1_rsp_ready;
    logic [31:0] d1_addr, d1_data, d1_rsp_data, d1_mreq_addr, d1_mreq_data, d1_mrsp_data;
    logic [3:0]  d1_byteen, d1_mreq_byteen;
    logic [7:0]  d1_tag, d1_rsp_tag;
    logic        d1_mreq_valid, d1_mreq_rw, d1_mreq_ready, d1_mrsp_valid, d1_mrsp_ready;
    logic [8:0]  d1_mreq_tag, d1_mrsp_tag;

    vx_socket_mem_arb #(.NUM_REQS(N), .ADDR_WIDTH(AW), .DATA_SIZE(DS), .TAG_WIDTH(TW)) dut (
        .clk(clk), .reset(reset),
        .req_valid_in(req_valid_in), .req_rw_in(req_rw_in), .req_addr_in(req_addr_in),
        .req_data_in(req_data_in), .req_byteen_in(req_byteen_in), .req_tag_in(req_tag_in),
        .req_ready_in(req_ready_in),
        .rsp_valid_out(rsp_valid_out), .rsp_data_out(rsp_data_out),
        .rsp_tag_out(rsp_tag_out), .rsp_ready_out(rsp_ready_out),
        .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
        .mem_req_data(mem_req_data), .mem_req_byteen(mem_req_byteen),
        .mem_req_tag(mem_req_tag), .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .mem_rsp_tag(mem_rsp_tag), .mem_rsp_ready(mem_rsp_ready)
`ifdef VX_SOCKET_ARB_PERF_EN
        , .perf_stalls(perf_stalls)
`endif
    );

    vx_socket_mem_arb #(.NUM_REQS(1), .ADDR_WIDTH(32), .DATA_SIZE(4), .TAG_WIDTH(8)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid_in(d1_valid), .req_rw_in(d1_rw), .req_addr_in(d1_addr),
        .req_data_in(d1_data), .req_byteen_in(d1_byteen), .req_tag_in(d1_tag),
        .req_ready_in(d1_ready),
        .rsp_valid_out(d1_rsp_valid), .rsp_data_out(d1_rsp_data),
        .rsp_tag_out(d1_rsp_tag), .rsp_ready_out(d1_rsp_ready),
        .mem_req_valid(d1_mreq_valid), .mem_req_rw(d1_mreq_rw), .mem_req_addr(d1_mreq_addr),
        .mem_req_data(d1_mreq_data), .mem_req_byteen(d1_mreq_byteen),
        .mem_req_tag(d1_mreq_tag), .mem_req_ready(d1_mreq_ready),
        .mem_rsp_valid(d1_mrsp_valid), .mem_rsp_data(d1_mrsp_data),
        .mem_rsp_tag(d1_mrsp_tag), .mem_rsp_ready(d1_mrsp_ready)
`ifdef VX_SOCKET_ARB_PERF_EN
        , .perf_stalls(d1_perf)
`endif
    );

    typedef struct {
        logic [N-1:0] v;
        logic         mrdy;
        logic [N-1:0] exp_ready;
    } vec_t;

    typedef struct {
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [DS-1:0] byteen;
        logic [XT-1:0] tag;
    } ent_t;

    vec_t vecs [NV];
    ent_t sb[$];
    int   ntests = 0;
    int   nfail  = 0;

    function automatic void chk(input string name, input logic [DW-1:0] act,
                                input logic [DW-1:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Payload requester i presents in vector seq; tag carries the expected index in its LSBs.
    function automatic ent_t mk(input int i, input int seq);
        ent_t e;
        e.addr   = 32'hA000_0000 + 32'(i * 256 + seq);
        e.data   = {16{e.addr}};
        e.byteen = {2{e.addr}};
        e.rw     = 1'((i + seq) % 2);
        e.tag    = {8'(8'h58 + i + 16 * seq), 2'(i)};
        return e;
    endfunction

    function automatic int oh_idx(input logic [N-1:0] oh);
        int r = 0;
        for (int i = 0; i < N; i++) if (oh[i]) r = i;
        return r;
    endfunction

    task automatic drive(input logic [N-1:0] v, input logic mrdy, input int seq);
        ent_t e;
        req_valid_in  = v;
        mem_req_ready = mrdy;
        for (int i = 0; i < N; i++) begin
            e = mk(i, seq);
            req_rw_in[i]                = e.rw;
            req_addr_in[i*AW +: AW]     = e.addr;
            req_data_in[i*DW +: DW]     = e.data;
            req_byteen_in[i*DS +: DS]   = e.byteen;
            req_tag_in[i*TW +: TW]      = e.tag[XT-1:2];
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{4'b0100, 1'b1, 4'b0100};  // single request, tag 0x5A
        vecs[1]  = '{4'b0000, 1'b1, 4'b0000};
        vecs[2]  = '{4'b1111, 1'b1, 4'b1000};  // rr_ptr=3 after requester 2
        vecs[3]  = '{4'b1111, 1'b1, 4'b0001};
        vecs[4]  = '{4'b1111, 1'b1, 4'b0010};
        vecs[5]  = '{4'b1111, 1'b1, 4'b0100};
        vecs[6]  = '{4'b1111, 1'b1, 4'b1000};
        vecs[7]  = '{4'b1111, 1'b1, 4'b0001};
        vecs[8]  = '{4'b1010, 1'b1, 4'b0010};
        vecs[9]  = '{4'b1010, 1'b1, 4'b1000};
        vecs[10] = '{4'b0110, 1'b1, 4'b0010};  // rr_ptr=2, buffer holds requester 1
        for (int k = 11; k < 16; k++) vecs[k] = '{4'b1000, 1'b0, 4'b0000};
        vecs[16] = '{4'b1001, 1'b1, 4'b1000};  // held rr_ptr=2 must pick 3, not 0
        vecs[17] = '{4'b0000, 1'b1, 4'b0000};

        reset = 1'b1;
        drive(4'b0000, 1'b0, 0);
        rsp_ready_out = '0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_tag = '0;
        d1_valid = 1'b0; d1_rw = 1'b0; d1_addr = 32'h0; d1_data = 32'h0; d1_byteen = 4'h0;
        d1_tag = 8'h0; d1_rsp_ready = 1'b0; d1_mreq_ready = 1'b0; d1_mrsp_valid = 1'b0;
        d1_mrsp_data = 32'h0; d1_mrsp_tag = 9'h0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        chk("reset mem_req_valid", DW'(mem_req_valid), DW'(1'b0));
        chk("reset req_ready_in", DW'(req_ready_in), DW'(4'b0000));
        chk("reset rsp_valid_out", DW'(rsp_valid_out), DW'(4'b0000));
`ifdef VX_SOCKET_ARB_PERF_EN
        chk("reset perf_stalls", DW'(perf_stalls), DW'(0));
`endif
        @(posedge clk); #1;

        for (int k = 0; k < NV; k++) begin
            drive(vecs[k].v, vecs[k].mrdy, k);
            @(negedge clk);
            chk($sformatf("vec%0d req_ready_in", k), DW'(req_ready_in), DW'(vecs[k].exp_ready));
            chk($sformatf("vec%0d mem_req_valid", k), DW'(mem_req_valid), DW'(sb.size() != 0));
            if (sb.size() != 0) begin
                chk($sformatf("vec%0d mem_req_tag", k), DW'(mem_req_tag), DW'(sb[0].tag));
                chk($sformatf("vec%0d mem_req_addr", k), DW'(mem_req_addr), DW'(sb[0].addr));
                chk($sformatf("vec%0d mem_req_data", k), mem_req_data, sb[0].data);
                chk($sformatf("vec%0d mem_req_byteen", k), DW'(mem_req_byteen),
                    DW'(sb[0].byteen));
                chk($sformatf("vec%0d mem_req_rw", k), DW'(mem_req_rw), DW'(sb[0].rw));
                if (vecs[k].mrdy) void'(sb.pop_front());
            end
            if (vecs[k].exp_ready != 0) sb.push_back(mk(oh_idx(vecs[k].exp_ready), k));
            @(posedge clk); #1;
        end
        chk("scoreboard drained", DW'(sb.size()), DW'(0));
`ifdef VX_SOCKET_ARB_PERF_EN
        chk("perf_stalls after 5 stalls", DW'(perf_stalls), DW'(5));
`endif

        // Response routing to requester 3, then requester 1
        mem_rsp_valid = 1'b1;
        mem_rsp_tag   = {8'h33, 2'd3};
        mem_rsp_data  = {16{32'hC0FF_EE11}};
        rsp_ready_out = 4'b0000;
        #2;
        chk("rsp3 valid (not ready)", DW'(rsp_valid_out), DW'(4'b1000));
        chk("rsp3 tag (not ready)", DW'(rsp_tag_out), DW'(8'h33));
        chk("rsp3 data", rsp_data_out, {16{32'hC0FF_EE11}});
        chk("rsp3 mem_rsp_ready low", DW'(mem_rsp_ready), DW'(1'b0));
        rsp_ready_out = 4'b1000;
        #2;
        chk("rsp3 valid (ready)", DW'(rsp_valid_out), DW'(4'b1000));
        chk("rsp3 tag (ready)", DW'(rsp_tag_out), DW'(8'h33));
        chk("rsp3 mem_rsp_ready high", DW'(mem_rsp_ready), DW'(1'b1));
        mem_rsp_tag   = {8'hC4, 2'd1};
        rsp_ready_out = 4'b1101;
        #2;
        chk("rsp1 valid", DW'(rsp_valid_out), DW'(4'b0010));
        chk("rsp1 tag", DW'(rsp_tag_out), DW'(8'hC4));
        chk("rsp1 mem_rsp_ready", DW'(mem_rsp_ready), DW'(1'b0));
        mem_rsp_valid = 1'b0;
        #2;
        chk("rsp idle valid", DW'(rsp_valid_out), DW'(4'b0000));
        rsp_ready_out = 4'b0000;
        @(posedge clk); #1;

        // Reset with a request buffered and rr_ptr=3
        drive(4'b0100, 1'b1, 40);
        @(posedge clk); #1;
        drive(4'b0000, 1'b0, 41);
        @(negedge clk);
        chk("pre-reset mem_req_valid", DW'(mem_req_valid), DW'(1'b1));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("post-reset mem_req_valid", DW'(mem_req_valid), DW'(1'b0));
        drive(4'b1111, 1'b1, 42);
        @(negedge clk);
        chk("post-reset first grant", DW'(req_ready_in), DW'(4'b0001));
        @(posedge clk); #1;
        chk("post-reset mem_req_tag", DW'(mem_req_tag), DW'(mk(0, 42).tag));
        drive(4'b0000, 1'b1, 43);
        @(posedge clk); #1;

        // NUM_REQS=1
        d1_valid = 1'b1; d1_tag = 8'h07; d1_addr = 32'h1234_5678; d1_mreq_ready = 1'b1;
        @(negedge clk);
        chk("n1 req_ready_in", DW'(d1_ready), DW'(1'b1));
        @(posedge clk); #1;
        d1_valid = 1'b0;
        chk("n1 mem_req_valid", DW'(d1_mreq_valid), DW'(1'b1));
        chk("n1 mem_req_tag", DW'(d1_mreq_tag), DW'(9'h00E));
        chk("n1 mem_req_addr", DW'(d1_mreq_addr), DW'(32'h1234_5678));
        d1_mrsp_valid = 1'b1; d1_mrsp_tag = {8'h44, 1'b0}; d1_rsp_ready = 1'b1;
        #1;
        chk("n1 rsp_valid_out", DW'(d1_rsp_valid), DW'(1'b1));
        chk("n1 rsp_tag_out", DW'(d1_rsp_tag), DW'(8'h44));
        chk("n1 mem_rsp_ready high", DW'(d1_mrsp_ready), DW'(1'b1));
        d1_rsp_ready = 1'b0;
        #1;
        chk("n1 mem_rsp_ready low", DW'(d1_mrsp_ready), DW'(1'b0));
        d1_mrsp_valid = 1'b0;
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
